// File: rtl/pkt_frame_fifo_pkg.sv
// rtl/pkt_frame_fifo_pkg.sv - shared constants and write-FSM state type for pkt_frame_fifo
package pkt_frame_fifo_pkg;

  // Packetizer word layout: bit 8 flags a payload byte, bits 7:0 carry the byte.
  localparam int WORD_W      = 9;
  localparam int PAYLOAD_BIT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/pkt_fifo_ram.sv
// rtl/pkt_fifo_ram.sv - simple dual-port byte RAM, synchronous write and synchronous read
module pkt_fifo_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // Write port and registered read port; rd_data holds its value while rd_en is low.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pkt_frame_fifo.sv
// rtl/pkt_frame_fifo.sv - packet FIFO committing whole packets only; PKT_FRAME_FIFO_DROP_CNT_EN adds drop_count
module pkt_frame_fifo
  import pkt_frame_fifo_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              pkt_avail,
  output logic              overflow,
`ifdef PKT_FRAME_FIFO_DROP_CNT_EN
  output logic [CNT_W-1:0]  drop_count,
`endif
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Extra wrap bit distinguishes full from empty.
  logic [ADDR_W:0] wptr, cptr, rptr;
  logic [DEPTH-1:0] flags;
  wr_state_t state, state_nxt;

  logic wr_en, commit, drop_start;
  logic full, is_payload, rd_issue;
  logic [ADDR_W-1:0] widx, ridx, last_idx;
  logic [7:0] ram_q;

  assign widx       = wptr[ADDR_W-1:0];
  assign ridx       = rptr[ADDR_W-1:0];
  assign last_idx   = widx - IDX_ONE;
  assign is_payload = in_word[PAYLOAD_BIT];
  assign full       = (widx == ridx) && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign pkt_avail  = (rptr != cptr);
  // Refill the output slot whenever it is empty or being emptied this cycle.
  assign rd_issue   = pkt_avail && (!out_valid || out_ready);
  // RAM output register doubles as the output data register; blank it when idle.
  assign out_data   = out_valid ? ram_q : 8'h00;

  pkt_fifo_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (widx),
    .wr_data (in_word[7:0]),
    .rd_en   (rd_issue),
    .rd_addr (ridx),
    .rd_data (ram_q)
  );

  // Write FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Write FSM next state: store, commit on terminator, or discard an overflowing packet.
  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    commit     = 1'b0;
    drop_start = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          if (is_payload) begin
            if (full) begin
              drop_start = 1'b1;
              state_nxt  = DROP;
            end else begin
              wr_en     = 1'b1;
              state_nxt = FILL;
            end
          end
        end
        FILL: begin
          if (is_payload) begin
            if (full) begin
              drop_start = 1'b1;
              state_nxt  = DROP;
            end else begin
              wr_en = 1'b1;
            end
          end else begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end
        end
        DROP: begin
          if (!is_payload) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Write and commit pointers plus per-packet status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      cptr      <= '0;
      pkt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= drop_start;
      if (wr_en)           wptr <= wptr + PTR_ONE;
      else if (drop_start) wptr <= cptr;
      if (commit) begin
        cptr      <= wptr;
        pkt_count <= pkt_count + CNT_ONE;
      end
    end
  end

  // End-of-packet flags: cleared as each byte lands, set on the last byte at commit.
  always_ff @(posedge clk) begin
    if (wr_en)  flags[widx]     <= 1'b0;
    if (commit) flags[last_idx] <= 1'b1;
  end

  // Read pointer and single output slot; holds the beat while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (rd_issue) begin
      rptr      <= rptr + PTR_ONE;
      out_valid <= 1'b1;
      out_last  <= flags[ridx];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

`ifdef PKT_FRAME_FIFO_DROP_CNT_EN
  // Saturating count of dropped packets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop_start && (drop_count != {CNT_W{1'b1}})) begin
      drop_count <= drop_count + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_frame_fifo.sv
// tb/tb_pkt_frame_fifo.sv - scoreboard testbench for pkt_frame_fifo
module tb_pkt_frame_fifo;

  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [8:0]       in_word;
  logic             in_valid;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             pkt_avail;
  logic             overflow;
  logic [CNT_W-1:0] pkt_count;
`ifdef PKT_FRAME_FIFO_DROP_CNT_EN
  logic [CNT_W-1:0] drop_count;
`endif

  int checks    = 0;
  int failures  = 0;
  int rx_count  = 0;
  int ovf_count = 0;
  int exp_count = 0;
  bit rnd_ready = 1'b0;
  logic [8:0] sb[$];
  logic [8:0] mon_exp;

  pkt_frame_fifo #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .pkt_avail (pkt_avail),
    .overflow  (overflow),
`ifdef PKT_FRAME_FIFO_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  // Randomised consumer readiness, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: every accepted beat must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (overflow) ovf_count++;
      if (out_valid && out_ready) begin
        checks++;
        rx_count++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected got=%h expected=none", {out_last, out_data});
        end else begin
          mon_exp = sb.pop_front();
          if ({out_last, out_data} !== mon_exp) begin
            failures++;
            $display("FAIL beat got=%h expected=%h", {out_last, out_data}, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic send_word(input logic [8:0] w);
    in_word  = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_word  = 9'h000;
  endtask

  task automatic send_pkt(input int n, input bit keep);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (keep) sb.push_back({1'(i == n - 1), b});
      send_word({1'b1, b});
    end
    send_word(9'h000);
    if (keep) exp_count++;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      failures++;
      $display("FAIL %s_drain pending=%0d expected=0", name, sb.size());
    end
  endtask

  task automatic check_count(input string name);
    checks++;
    if (pkt_count !== CNT_W'(exp_count)) begin
      failures++;
      $display("FAIL %s_pkt_count got=%0d expected=%0d", name, pkt_count, exp_count);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_word = 9'h000; out_ready = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
    checks++; if (out_last  !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b expected=0", out_last); end
    checks++; if (out_data  !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h expected=00", out_data); end
    checks++; if (pkt_avail !== 1'b0) begin failures++; $display("FAIL reset_pkt_avail got=%b expected=0", pkt_avail); end
    checks++; if (overflow  !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b expected=0", overflow); end
    check_count("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    sb.push_back(9'h0FF); sb.push_back(9'h00D); sb.push_back(9'h10A);
    send_word(9'h1FF); send_word(9'h10D); send_word(9'h10A); send_word(9'h000);
    exp_count++;
    checks++; if (pkt_avail !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_commit avail/valid got=%b%b expected=10", pkt_avail, out_valid);
    end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_latency out_valid got=%b expected=1", out_valid); end
    wait_drain("single", 50);
    check_count("single");
  endtask

  task automatic test_terminators;
    out_ready = 1'b1;
    ovf_count = 0;
    send_word(9'h000); send_word(9'h000); send_word(9'h000);
    sb.push_back(9'h155);
    send_word(9'h155); send_word(9'h000); send_word(9'h000);
    exp_count++;
    wait_drain("term", 50);
    check_count("term");
    checks++; if (ovf_count != 0) begin failures++; $display("FAIL term_overflow got=%0d expected=0", ovf_count); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send_pkt(8, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sb.size() == 0 || {out_last, out_data} !== sb[0]) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got=%b/%h expected=1/%h", i, out_valid, {out_last, out_data},
                 (sb.size() != 0) ? sb[0] : 9'h000);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain("bp", 50);
    check_count("bp");
  endtask

  task automatic test_overflow;
    out_ready = 1'b0;
    ovf_count = 0;
    send_pkt(11, 1'b1);
    send_pkt(7, 1'b0);
    send_pkt(3, 1'b1);
    @(posedge clk); #1;
    checks++; if (ovf_count != 1) begin failures++; $display("FAIL ovf_pulses got=%0d expected=1", ovf_count); end
    check_count("ovf");
`ifdef PKT_FRAME_FIFO_DROP_CNT_EN
    checks++; if (drop_count !== CNT_W'(1)) begin failures++; $display("FAIL ovf_drop_count got=%0d expected=1", drop_count); end
`endif
    out_ready = 1'b1;
    wait_drain("ovf", 100);
  endtask

  task automatic test_wrap;
    int base;
    int n;
    base = rx_count;
    rnd_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      n = 0;
      while (sb.size() > DEPTH - 5 && n < 200) begin
        @(posedge clk); #1; n++;
      end
      send_pkt(5, 1'b1);
    end
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("wrap", 500);
    checks++; if (rx_count - base != 200) begin failures++; $display("FAIL wrap_bytes got=%0d expected=200", rx_count - base); end
    check_count("wrap");
  endtask

  task automatic test_reset_mid_drain;
    out_ready = 1'b0;
    send_pkt(4, 1'b1);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b expected=1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b expected=0", out_valid); end
    checks++; if (pkt_avail !== 1'b0) begin failures++; $display("FAIL rstmid_pkt_avail got=%b expected=0", pkt_avail); end
    sb.delete();
    exp_count = 0;
    check_count("rstmid");
`ifdef PKT_FRAME_FIFO_DROP_CNT_EN
    checks++; if (drop_count !== '0) begin failures++; $display("FAIL rstmid_drop_count got=%0d expected=0", drop_count); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_pkt(3, 1'b1);
    wait_drain("rstmid", 50);
    check_count("rstmid_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_terminators();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
